// File: rtl/conv_pkg.sv
// Shared definitions for the convolution write side: default geometry and writer FSM states.
package conv_pkg;
  localparam int IMG_SIZE = 256;
  localparam int KER_SIZE = 3;
  localparam int OUT_W    = IMG_SIZE - KER_SIZE + 1;
  localparam int OUT_PIX  = OUT_W * OUT_W;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
endpackage

// File: rtl/conv_result_writer_pix_clamp.sv
// Combinational accumulator-to-pixel clamp with saturation flag.
// With ABS_MAG_EN defined the clamp operates on |i_data| (magnitude output for edge kernels).
module pix_clamp
  import conv_pkg::*;
#(
  parameter int ACC_W = 20
)(
  input  logic signed [ACC_W-1:0] i_data,
  output logic        [7:0]       o_pix,
  output logic                    o_sat
);
  logic             w_neg;
  logic             w_zero;
  logic             w_big;
  logic [ACC_W:0]   w_ext;
  logic [ACC_W:0]   w_mag;

  // One extra bit so that negating the most negative sum cannot overflow.
  assign w_neg = i_data[ACC_W-1];
  assign w_ext = {w_neg, i_data};

`ifdef ABS_MAG_EN
  assign w_mag  = w_neg ? ((ACC_W+1)'(0) - w_ext) : w_ext;
  assign w_zero = 1'b0;
`else
  assign w_mag  = w_ext;
  assign w_zero = w_neg;
`endif

  assign w_big = |w_mag[ACC_W:8];
  assign o_pix = w_zero ? 8'd0 : (w_big ? 8'hFF : w_mag[7:0]);
  assign o_sat = !w_zero && w_big;
endmodule

// File: rtl/conv_result_writer.sv
// Convolution result writer: clamps MAC results to pixels and writes them to the filtered RAM
// in raster order, pulsing o_done after the last write. ABS_MAG_EN selects magnitude clamping.
module conv_result_writer
  import conv_pkg::*;
#(
  parameter int               IMG_SIZE  = conv_pkg::IMG_SIZE,
  parameter int               KER_SIZE  = conv_pkg::KER_SIZE,
  parameter int               ACC_W     = 20,
  parameter int               ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
)(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic signed [ACC_W-1:0] i_in_data,
  output logic                    o_wr_en,
  input  logic                    i_wr_ready,
  output logic [ADDR_W-1:0]       o_wr_addr,
  output logic [7:0]              o_wr_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [15:0]             o_sat_cnt
);
  localparam int OUT_W_L = IMG_SIZE - KER_SIZE + 1;
  localparam int CNT_W   = (OUT_W_L > 1) ? $clog2(OUT_W_L) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(OUT_W_L - 1);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_row, r_col;
  logic [15:0]       r_sat;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              w_accept, w_wr_done, w_last, w_start, w_sat;
  logic [7:0]        w_pix;

  pix_clamp #(.ACC_W(ACC_W)) u_clamp (
    .i_data (i_in_data),
    .o_pix  (w_pix),
    .o_sat  (w_sat)
  );

  assign w_wr_done  = r_wr_en && i_wr_ready;
  assign o_in_ready = (r_state == RUN) && (!r_wr_en || i_wr_ready);
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_last     = (r_row == LAST) && (r_col == LAST);
  assign w_start    = (r_state == IDLE) && i_start;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = RUN;
      RUN:     if (w_accept && w_last) w_next = FLUSH;
      FLUSH:   if (w_wr_done) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr <= '0;
      r_row  <= '0;
      r_col  <= '0;
      r_sat  <= '0;
    end else if (w_start) begin
      r_addr <= BASE_ADDR;
      r_row  <= '0;
      r_col  <= '0;
      r_sat  <= '0;
    end else if (w_accept) begin
      r_addr <= r_addr + 1'b1;
      if (r_col == LAST) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
      if (w_sat && (r_sat != 16'hFFFF)) r_sat <= r_sat + 16'd1;
    end
  end

  // Single-entry output register; a new beat only lands when the old write is granted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_accept) begin
      r_wr_en   <= 1'b1;
      r_wr_addr <= r_addr;
      r_wr_data <= w_pix;
    end else if (w_wr_done) begin
      r_wr_en   <= 1'b0;
    end
  end

  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
  assign o_busy    = (r_state == RUN) || (r_state == FLUSH);
  assign o_done    = (r_state == DONE);
  assign o_sat_cnt = r_sat;
endmodule

// File: tb/tb_conv_result_writer.sv
// Self-checking bench for conv_result_writer: randomized streams vs. a clamp/address model.
module tb_conv_result_writer;
  localparam int ACC_W = 20;
  localparam int N1    = 16;   // IMG_SIZE 6, KER_SIZE 3 -> 4x4
  localparam int N2    = 324;  // IMG_SIZE 20, KER_SIZE 3 -> 18x18
  localparam int BASE2 = 'h1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, in_valid = 1'b0, wr_ready = 1'b1;
  logic signed [ACC_W-1:0] in_data = '0;
  logic in_ready, wr_en, busy, done;
  logic [15:0] wr_addr, sat_cnt;
  logic [7:0] wr_data;

  logic b_start = 1'b0, b_in_valid = 1'b0, b_wr_ready = 1'b1;
  logic signed [ACC_W-1:0] b_in_data = '0;
  logic b_in_ready, b_wr_en, b_busy, b_done;
  logic [15:0] b_wr_addr, b_sat_cnt;
  logic [7:0] b_wr_data;

  always #5 clk = ~clk;

  conv_result_writer #(.IMG_SIZE(6), .KER_SIZE(3), .ACC_W(ACC_W), .ADDR_W(16), .BASE_ADDR(16'h0000)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_data(in_data), .o_wr_en(wr_en), .i_wr_ready(wr_ready), .o_wr_addr(wr_addr),
    .o_wr_data(wr_data), .o_busy(busy), .o_done(done), .o_sat_cnt(sat_cnt));

  conv_result_writer #(.IMG_SIZE(20), .KER_SIZE(3), .ACC_W(ACC_W), .ADDR_W(16), .BASE_ADDR(16'h1000)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_in_valid(b_in_valid), .o_in_ready(b_in_ready),
    .i_in_data(b_in_data), .o_wr_en(b_wr_en), .i_wr_ready(b_wr_ready), .o_wr_addr(b_wr_addr),
    .o_wr_data(b_wr_data), .o_busy(b_busy), .o_done(b_done), .o_sat_cnt(b_sat_cnt));

  int n_tests = 0, n_fail = 0;

  // Reference model: pixel value and saturation rule straight from the clamp definition.
  function automatic int mdl_mag(int v);
`ifdef ABS_MAG_EN
    return (v < 0) ? -v : v;
`else
    return (v < 0) ? 0 : v;
`endif
  endfunction
  function automatic int mdl_pix(int v);
    return (mdl_mag(v) > 255) ? 255 : mdl_mag(v);
  endfunction
  function automatic int mdl_sat(int vals[$]);
    int c = 0;
    foreach (vals[i]) if (mdl_mag(vals[i]) > 255) c++;
    return (c > 65535) ? 65535 : c;
  endfunction
  function automatic int rnd_val();
    return int'($urandom_range(800)) - 400;
  endfunction

  // Per-cycle observation of DUT 1 (no checking here, only recording).
  logic s_acc, s_wc, s_rdy, p_hold;
  logic [15:0] p_addr;
  logic [7:0] p_data;
  int obs_addr[$], obs_data[$];
  int done_cnt, done_cyc, hold_viol, rdy_viol;
  bit timed_out;

  task automatic cycle();
    @(negedge clk);
    s_acc = in_valid && in_ready;
    s_wc  = wr_en && wr_ready;
    s_rdy = in_ready;
    if (p_hold && (!wr_en || wr_addr != p_addr || wr_data != p_data)) hold_viol++;
    p_hold = wr_en && !wr_ready;
    p_addr = wr_addr;
    p_data = wr_data;
    if (s_wc) begin
      obs_addr.push_back(int'(wr_addr));
      obs_data.push_back(int'(wr_data));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input int vals[$], input int gap_pct, input int stall_at,
                             input int stall_len, input int start_mid_at);
    int cyc, idx, post;
    bit stall;
    obs_addr.delete(); obs_data.delete();
    done_cnt = 0; done_cyc = -1; hold_viol = 0; rdy_viol = 0; timed_out = 0; p_hold = 0;
    start = 1; in_valid = 0; wr_ready = 1;
    cycle();
    start = 0; cyc = 1; idx = 0; post = 0;
    forever begin
      stall    = (stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + stall_len);
      wr_ready = !stall;
      start    = (cyc == start_mid_at);
      in_valid = (idx < vals.size()) && ($urandom_range(99) >= gap_pct);
      in_data  = in_valid ? ACC_W'(vals[idx]) : ACC_W'($urandom);
      cycle();
      cyc++;
      if (s_acc) idx++;
      if (stall && s_rdy) rdy_viol++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0) post++;
      if (post > 4) break;
      if (cyc > 3000) begin timed_out = 1; break; end
    end
    start = 0; in_valid = 0; wr_ready = 1;
  endtask

  task automatic check_stream(input string tag, input int vals[$]);
    n_tests++;
    if (timed_out !== 1'b0) begin n_fail++; $display("FAIL %s timeout: no done seen", tag); end
    n_tests++;
    if (obs_addr.size() != vals.size()) begin
      n_fail++; $display("FAIL %s write count: got %0d want %0d", tag, obs_addr.size(), vals.size());
    end
    for (int i = 0; i < vals.size() && i < obs_addr.size(); i++) begin
      n_tests++;
      if (obs_addr[i] !== i || obs_data[i] !== mdl_pix(vals[i])) begin
        n_fail++;
        $display("FAIL %s write[%0d]: got addr %0d data %0d want addr %0d data %0d",
                 tag, i, obs_addr[i], obs_data[i], i, mdl_pix(vals[i]));
      end
    end
    n_tests++;
    if (int'(sat_cnt) !== mdl_sat(vals)) begin
      n_fail++; $display("FAIL %s sat_cnt: got %0d want %0d", tag, sat_cnt, mdl_sat(vals));
    end
    n_tests++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL %s done pulses: got %0d want 1", tag, done_cnt); end
    n_tests++;
    if (hold_viol !== 0) begin n_fail++; $display("FAIL %s write hold: got %0d changes want 0", tag, hold_viol); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
    n_tests++; if (wr_en !== 1'b0)    begin n_fail++; $display("FAIL reset wr_en: got %b want 0", wr_en); end
    n_tests++; if (wr_addr !== 16'd0) begin n_fail++; $display("FAIL reset wr_addr: got %0d want 0", wr_addr); end
    n_tests++; if (wr_data !== 8'd0)  begin n_fail++; $display("FAIL reset wr_data: got %0d want 0", wr_data); end
    n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset done: got %b want 0", done); end
    n_tests++; if (sat_cnt !== 16'd0) begin n_fail++; $display("FAIL reset sat_cnt: got %0d want 0", sat_cnt); end
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    int vals[$];
    for (int k = 0; k < N1; k++) vals.push_back(k);
    drive_frame(vals, 0, -1, 0, -1);
    check_stream("stream", vals);
    n_tests++;
    if (done_cyc !== 18) begin n_fail++; $display("FAIL stream done latency: got %0d want 18", done_cyc); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL stream busy after done: got %b want 0", busy); end
  endtask

  task automatic test_clamp();
    int vals[$];
    vals = '{-5, 300, 255, 0};
    while (vals.size() < N1) vals.push_back(rnd_val());
    drive_frame(vals, 30, -1, 0, -1);
    check_stream("clamp", vals);
  endtask

  task automatic test_stall();
    int vals[$];
    for (int k = 0; k < N1; k++) vals.push_back(rnd_val());
    drive_frame(vals, 0, 6, 4, -1);
    check_stream("stall", vals);
    n_tests++;
    if (rdy_viol !== 0) begin n_fail++; $display("FAIL stall in_ready: got %0d ready cycles want 0", rdy_viol); end
  endtask

  task automatic test_start_mid();
    int vals[$];
    for (int k = 0; k < N1; k++) vals.push_back(rnd_val());
    drive_frame(vals, 10, -1, 0, 5);
    check_stream("start_mid", vals);
  endtask

  task automatic test_rst_mid();
    int vals[$];
    int acc = 0, guard = 0;
    start = 1; cycle(); start = 0;
    in_valid = 1; wr_ready = 1;
    while (acc < 7 && guard < 50) begin
      in_data = ACC_W'(rnd_val());
      cycle();
      if (s_acc) acc++;
      guard++;
    end
    in_valid = 0;
    n_tests++;
    if (wr_en !== 1'b1) begin n_fail++; $display("FAIL rst_mid write in flight: got %b want 1", wr_en); end
    #2 rst = 1;
    #1;
    n_tests++; if (wr_en !== 1'b0)    begin n_fail++; $display("FAIL rst_mid wr_en: got %b want 0", wr_en); end
    n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_mid busy: got %b want 0", busy); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1 rst = 0;
    for (int k = 0; k < N1; k++) vals.push_back(rnd_val());
    drive_frame(vals, 20, -1, 0, -1);
    check_stream("rst_restart", vals);
  endtask

  task automatic test_base();
    int vals[$], oa[$], od[$];
    int idx = 0, cyc = 0, dn = 0, post = 0;
    bit acc, wc;
    for (int k = 0; k < N2; k++) vals.push_back((k % 7 == 0) ? 1000 : rnd_val());
    b_start = 1; @(posedge clk); #1 b_start = 0;
    forever begin
      b_in_valid = (idx < N2) && ($urandom_range(99) < 85);
      b_in_data  = b_in_valid ? ACC_W'(vals[idx]) : '0;
      b_wr_ready = ($urandom_range(99) < 80);
      @(negedge clk);
      acc = b_in_valid && b_in_ready;
      wc  = b_wr_en && b_wr_ready;
      if (wc) begin oa.push_back(int'(b_wr_addr)); od.push_back(int'(b_wr_data)); end
      @(posedge clk); #1;
      cyc++;
      if (acc) idx++;
      if (b_done) dn++;
      if (dn > 0) post++;
      if (post > 4 || cyc > 4000) break;
    end
    b_in_valid = 0; b_wr_ready = 1;
    n_tests++;
    if (oa.size() != N2) begin n_fail++; $display("FAIL base write count: got %0d want %0d", oa.size(), N2); end
    n_tests++;
    if (oa.size() > 0 && oa[0] !== BASE2) begin n_fail++; $display("FAIL base first addr: got %0h want %0h", oa[0], BASE2); end
    n_tests++;
    if (oa.size() > 0 && oa[oa.size()-1] !== BASE2 + N2 - 1) begin
      n_fail++; $display("FAIL base last addr: got %0h want %0h", oa[oa.size()-1], BASE2 + N2 - 1);
    end
    for (int i = 0; i < N2 && i < oa.size(); i++) begin
      n_tests++;
      if (oa[i] !== BASE2 + i || od[i] !== mdl_pix(vals[i])) begin
        n_fail++;
        $display("FAIL base write[%0d]: got addr %0h data %0d want addr %0h data %0d",
                 i, oa[i], od[i], BASE2 + i, mdl_pix(vals[i]));
      end
    end
    n_tests++;
    if (int'(b_sat_cnt) !== mdl_sat(vals)) begin
      n_fail++; $display("FAIL base sat_cnt: got %0d want %0d", b_sat_cnt, mdl_sat(vals));
    end
    n_tests++;
    if (dn !== 1) begin n_fail++; $display("FAIL base done pulses: got %0d want 1", dn); end
  endtask

  initial begin
    p_hold = 0;
    test_reset();
    test_stream();
    test_clamp();
    test_stall();
    test_start_mid();
    test_rst_mid();
    test_base();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
